// File: rtl/cpu_apb_pkg.sv
// rtl/cpu_apb_pkg.sv - shared types and widths for the CPU-side APB master
package cpu_apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One latched transfer: direction, address and (read-masked) write data
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    // Width of an index/counter able to hold values up to n-1 (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_apb_if.sv
// rtl/cpu_apb_if.sv - APB bus bundle with master and slave views
interface cpu_apb_if
    import cpu_apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, pointer moves past the winner on advance
module rr_arbiter
    import cpu_apb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = idx_w(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] grant_idx;

    // Grant the first requester found at or after the pointer, wrapping around
    always_comb begin
        grant = '0;
        for (int off = 0; off < N; off++) begin
            if (grant == '0 && req[(int'(ptr_q) + off) % N]) begin
                grant[(int'(ptr_q) + off) % N] = 1'b1;
            end
        end
    end

    // Binary index of the current winner
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // Next pointer: the requester just after the winner once it is accepted
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register; reset favours requester 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cpu_apb_master_ctrl.sv
// rtl/cpu_apb_master_ctrl.sv - arbitrated single-outstanding APB master with access timeout
module cpu_apb_master_ctrl
    import cpu_apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    cpu_apb_if.master               apb
);

    localparam int CNT_W = idx_w(TIMEOUT + 1);

    apb_state_e        state_q, state_d;
    apb_req_t          xfer_q, xfer_d;
    logic [N_REQ-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic              in_access;
    logic              done_ok;
    logic              timed_out;
    logic              psel_c;
    logic              penable_c;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign accept    = |req_ready;
    assign in_access = (state_q == ACCESS);
    assign done_ok   = in_access && apb.pready;
    // A late pready on the last allowed cycle still completes normally
    assign timed_out = (TIMEOUT != 0) && in_access && !apb.pready
                       && (cnt_q == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one SETUP cycle, then ACCESS until pready or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done_ok || timed_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: APB phase strobes and the one-hot accept
    always_comb begin
        req_ready = '0;
        psel_c    = 1'b0;
        penable_c = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:    if (!reset) req_ready = req_valid & grant;
            SETUP:   psel_c = 1'b1;
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the winner's request; later request changes cannot disturb it
    always_comb begin
        xfer_d  = xfer_q;
        owner_d = owner_q;
        if (accept) begin
            owner_d = req_ready;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    xfer_d.write = req_write[i];
                    xfer_d.addr  = req_addr[i*ADDR_W +: ADDR_W];
                    xfer_d.wdata = req_write[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
                end
            end
        end
    end

    // Wait-state counter and the completion response for the owner
    always_comb begin
        cnt_d = '0;
        if (in_access && !apb.pready && !timed_out) begin
            cnt_d = cnt_q + 1'b1;
        end
        rsp_valid_d = (done_ok || timed_out) ? owner_q : '0;
        rsp_rdata_d = (done_ok && !xfer_q.write) ? apb.prdata : '0;
        rsp_err_d   = timed_out;
    end

    // Transfer, counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_q      <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            xfer_q      <= xfer_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign apb.paddr   = xfer_q.addr;
    assign apb.pwrite  = xfer_q.write;
    assign apb.pwdata  = xfer_q.wdata;
    assign apb.psel    = psel_c;
    assign apb.penable = penable_c;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cpu_apb_master_ctrl.sv
// tb/tb_cpu_apb_master_ctrl.sv - scoreboard bench for the arbitrated APB master
module tb_cpu_apb_master_ctrl;

    typedef struct packed {
        logic [1:0]  v;
        logic [15:0] d;
        logic        e;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          acc_cnt;
    int          wait_cfg;
    logic [15:0] rdata_cfg;
    rsp_t        exp_q[$];

    cpu_apb_if apb_bus ();

    cpu_apb_master_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .N_REQ   (2),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .apb       (apb_bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: pready after wait_cfg not-ready ACCESS cycles
    always @(posedge clk or posedge reset) begin
        if (reset) acc_cnt <= 0;
        else if (apb_bus.psel && apb_bus.penable && !apb_bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign apb_bus.pready = apb_bus.psel && apb_bus.penable && (acc_cnt == wait_cfg);
    assign apb_bus.prdata = rdata_cfg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (|rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected rsp: rsp_valid=0x%0h with nothing expected", rsp_valid);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.v});
                chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.d});
                chk("rsp_err",   {31'd0, rsp_err},   {31'd0, e.e});
            end
        end
    end

    task automatic set_req(input int idx, input logic w, input logic [15:0] a, input logic [15:0] d);
        req_write[idx]        = w;
        req_addr[idx*16 +: 16]  = a;
        req_wdata[idx*16 +: 16] = d;
    endtask

    task automatic push_rsp(input logic [1:0] v, input logic [15:0] d, input logic e);
        rsp_t r;
        r.v = v;
        r.d = d;
        r.e = e;
        exp_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge where req_ready is seen
    task automatic wait_ready(input string name, input logic [1:0] exp, output int n);
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, {30'd0, req_ready}, {30'd0, exp});
    endtask

    // Called just after the accept edge; returns at the first negedge with psel low
    task automatic watch_xfer(input string name, input logic [15:0] a, input logic w,
                              input logic [15:0] wd, input int exp_cycles);
        int ps  = 0;
        int pe  = 0;
        int bad = 0;
        @(negedge clk);
        while (apb_bus.psel && ps < 60) begin
            ps++;
            if (apb_bus.penable) pe++;
            if (apb_bus.paddr !== a || apb_bus.pwrite !== w || apb_bus.pwdata !== wd) bad++;
            @(negedge clk);
        end
        chk({name, " psel cycles"}, ps, exp_cycles);
        chk({name, " penable cycles"}, pe, exp_cycles - 1);
        chk({name, " bus stable"}, bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int last;

        // 1. reset with both requesters pending
        reset     = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        wait_cfg  = 0;
        rdata_cfg = 16'hBEEF;
        set_req(0, 1'b0, 16'h0040, 16'hDEAD);
        set_req(1, 1'b1, 16'h1234, 16'hA5A5);
        repeat (2) @(negedge clk);
        chk("reset psel",      {31'd0, apb_bus.psel},    32'd0);
        chk("reset penable",   {31'd0, apb_bus.penable}, 32'd0);
        chk("reset busy",      {31'd0, busy},            32'd0);
        chk("reset req_ready", {30'd0, req_ready},       32'd0);
        chk("reset rsp_valid", {30'd0, rsp_valid},       32'd0);
        chk("reset paddr",     {16'd0, apb_bus.paddr},   32'd0);
        reset = 1'b0;
        wait_ready("t1 first grant", 2'b01, n);
        push_rsp(2'b01, 16'hBEEF, 1'b0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;

        // 2. zero-wait read; 3. write with three wait states back-to-back
        watch_xfer("t2 read", 16'h0040, 1'b0, 16'h0000, 2);
        wait_cfg = 3;
        wait_ready("t1 second grant", 2'b10, n);
        chk("t1 back-to-back accept", n, 0);
        push_rsp(2'b10, 16'h0000, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        watch_xfer("t3 write", 16'h1234, 1'b1, 16'hA5A5, 5);

        // 4. timeout with pready stuck low, then pready on the 16th ACCESS cycle
        wait_cfg  = 100;
        rdata_cfg = 16'h5555;
        set_req(0, 1'b0, 16'h0100, 16'h0000);
        req_valid = 2'b01;
        wait_ready("t4 grant", 2'b01, n);
        push_rsp(2'b01, 16'h0000, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        watch_xfer("t4 timeout", 16'h0100, 1'b0, 16'h0000, 17);
        wait_cfg  = 15;
        rdata_cfg = 16'h1357;
        set_req(1, 1'b0, 16'h0200, 16'h0000);
        req_valid = 2'b10;
        wait_ready("t4b grant", 2'b10, n);
        push_rsp(2'b10, 16'h1357, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        watch_xfer("t4b late ready", 16'h0200, 1'b0, 16'h0000, 17);

        // 5. both requesters streaming with zero wait states
        wait_cfg  = 0;
        rdata_cfg = 16'h0F0F;
        set_req(0, 1'b0, 16'h0A00, 16'h1111);
        set_req(1, 1'b1, 16'h0B00, 16'h7777);
        req_valid = 2'b11;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready($sformatf("t5 grant %0d", k), g, n);
            if (k > 0) begin
                chk($sformatf("t5 accept gap %0d", k), cyc - last, 3);
                chk($sformatf("t5 rsp aligned %0d", k), {30'd0, rsp_valid}, {30'd0, ~g});
            end
            last = cyc;
            if (k % 2 == 0) push_rsp(2'b01, 16'h0F0F, 1'b0);
            else            push_rsp(2'b10, 16'h0000, 1'b0);
            @(posedge clk); #1;
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
        end
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5 drained", {31'd0, busy}, 32'd0);

        // 6. reset in the second ACCESS cycle drops the transfer
        wait_cfg = 100;
        set_req(0, 1'b0, 16'h0300, 16'h0000);
        req_valid = 2'b01;
        wait_ready("t6 grant", 2'b01, n);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("t6 in access", {31'd0, apb_bus.penable}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 async psel",      {31'd0, apb_bus.psel},    32'd0);
        chk("t6 async penable",   {31'd0, apb_bus.penable}, 32'd0);
        chk("t6 async busy",      {31'd0, busy},            32'd0);
        chk("t6 async rsp_valid", {30'd0, rsp_valid},       32'd0);
        wait_cfg  = 0;
        rdata_cfg = 16'h2468;
        set_req(0, 1'b0, 16'h0400, 16'h0000);
        set_req(1, 1'b1, 16'h0500, 16'h9999);
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ready("t6 grant after reset", 2'b01, n);
        push_rsp(2'b01, 16'h2468, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        watch_xfer("t6 post-reset read", 16'h0400, 1'b0, 16'h0000, 2);
        repeat (3) @(negedge clk);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
